// File: rtl/store_buffer.sv
// store_buffer: in-order write-back buffer between core stores and data memory.
// Latency: push to MemReq is one cycle; forwarding lookup is combinational.
// Backpressure: Stall (registered) is high while all DEPTH entries are occupied;
//   the core holds its store. Memory side holds MemReq/MemAdr/MemWData until MemAck.
//
// Ports:
//   clk, reset               rising-edge clock, asynchronous active-high reset
//   MemWrite/DataAdr/WriteData  core store request (accepted when Stall=0)
//   Stall                    buffer full
//   ReadAdr/FwdHit/FwdData   store-to-load forwarding lookup (word granular)
//   MemReq/MemAdr/MemWData   head-entry write request to data memory
//   MemAck                   memory accepts the head entry this cycle
//   Count/Empty              occupancy
//
// Optional feature: define STORE_BUFFER_FWD_EN to build the forwarding compare
// logic. Without it FwdHit/FwdData are tied to 0 and ReadAdr is ignored.

module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    MemWrite,
  input  logic [AW-1:0]           DataAdr,
  input  logic [DW-1:0]           WriteData,
  output logic                    Stall,
  input  logic [AW-1:0]           ReadAdr,
  output logic                    FwdHit,
  output logic [DW-1:0]           FwdData,
  output logic                    MemReq,
  output logic [AW-1:0]           MemAdr,
  output logic [DW-1:0]           MemWData,
  input  logic                    MemAck,
  output logic [$clog2(DEPTH):0]  Count,
  output logic                    Empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] DRAIN = 1'b1;

  logic [AW-1:0] ent_addr [DEPTH];
  logic [DW-1:0] ent_data [DEPTH];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] cnt, cnt_next;
  logic          stall_q;
  logic [0:0]    state, state_next;
  logic          push, pop;

  assign push = MemWrite & ~stall_q;
  // DRAIN implies at least one entry, so an ack in IDLE can never underflow.
  assign pop  = (state == DRAIN) & MemAck;

  always_comb begin
    cnt_next = cnt;
    case ({push, pop})
      2'b10:   cnt_next = cnt + CW'(1);
      2'b01:   cnt_next = cnt - CW'(1);
      default: cnt_next = cnt;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (push) state_next = DRAIN;
      DRAIN:   if (cnt_next == '0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head    <= '0;
      tail    <= '0;
      cnt     <= '0;
      stall_q <= 1'b0;
      state   <= IDLE;
      for (int i = 0; i < DEPTH; i++) begin
        ent_addr[i] <= '0;
        ent_data[i] <= '0;
      end
    end else begin
      if (push) begin
        ent_addr[tail] <= DataAdr;
        ent_data[tail] <= WriteData;
        tail           <= tail + PW'(1);
      end
      if (pop) begin
        head <= head + PW'(1);
      end
      cnt     <= cnt_next;
      // Stall is registered from next occupancy so a full-cycle pop frees the
      // slot for the held store on the following edge.
      stall_q <= (cnt_next == CW'(DEPTH));
      state   <= state_next;
    end
  end

  assign Stall    = stall_q;
  assign Count    = cnt;
  assign Empty    = (cnt == '0);
  assign MemReq   = (state == DRAIN);
  assign MemAdr   = MemReq ? ent_addr[head] : '0;
  assign MemWData = MemReq ? ent_data[head] : '0;

`ifdef STORE_BUFFER_FWD_EN
  logic [PW-1:0] idx;
  // Byte-offset bits do not take part in the word-address match.
  logic          unused_readadr_lsb;
  assign unused_readadr_lsb = ^ReadAdr[1:0];

  // Walk from oldest to youngest valid entry; a later match overrides an
  // earlier one so the youngest store wins. Only registered entries are
  // searched, so a store being pushed this cycle never forwards.
  always_comb begin
    FwdHit  = 1'b0;
    FwdData = '0;
    idx     = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PW'(k);
      if ((CW'(k) < cnt) && (ent_addr[idx][AW-1:2] == ReadAdr[AW-1:2])) begin
        FwdHit  = 1'b1;
        FwdData = ent_data[idx];
      end
    end
  end
`else
  logic unused_readadr;
  assign unused_readadr = ^ReadAdr;
  assign FwdHit  = 1'b0;
  assign FwdData = '0;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed self-checking bench for store_buffer.
// Latency: inputs change #1 after a rising edge; outputs sampled at that point.
// Backpressure: exercises full/Stall hold, held MemReq, and reset mid-drain.

module tb_store_buffer;

  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    MemWrite;
  logic [AW-1:0]           DataAdr;
  logic [DW-1:0]           WriteData;
  logic                    Stall;
  logic [AW-1:0]           ReadAdr;
  logic                    FwdHit;
  logic [DW-1:0]           FwdData;
  logic                    MemReq;
  logic [AW-1:0]           MemAdr;
  logic [DW-1:0]           MemWData;
  logic                    MemAck;
  logic [$clog2(DEPTH):0]  Count;
  logic                    Empty;

  int checks = 0;
  int errors = 0;

  store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .DataAdr   (DataAdr),
    .WriteData (WriteData),
    .Stall     (Stall),
    .ReadAdr   (ReadAdr),
    .FwdHit    (FwdHit),
    .FwdData   (FwdData),
    .MemReq    (MemReq),
    .MemAdr    (MemAdr),
    .MemWData  (MemWData),
    .MemAck    (MemAck),
    .Count     (Count),
    .Empty     (Empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [AW-1:0] exp_order [4];
  logic          fwd_on;

  initial begin
`ifdef STORE_BUFFER_FWD_EN
    fwd_on = 1'b1;
`else
    fwd_on = 1'b0;
`endif
    reset     = 1'b1;
    MemWrite  = 1'b0;
    DataAdr   = '0;
    WriteData = '0;
    ReadAdr   = '0;
    MemAck    = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    check("rst_count",  64'(Count),    64'd0);
    check("rst_empty",  64'(Empty),    64'd1);
    check("rst_stall",  64'(Stall),    64'd0);
    check("rst_memreq", 64'(MemReq),   64'd0);
    check("rst_memadr", 64'(MemAdr),   64'd0);
    check("rst_wdata",  64'(MemWData), 64'd0);
    check("rst_fwdhit", 64'(FwdHit),   64'd0);
    check("rst_fwddat", 64'(FwdData),  64'd0);
    reset = 1'b0;

    // Single store, one-cycle push-to-request latency, then ack
    MemWrite = 1'b1; DataAdr = 100; WriteData = 7;
    step();
    MemWrite = 1'b0;
    check("s1_memreq", 64'(MemReq),   64'd1);
    check("s1_memadr", 64'(MemAdr),   64'd100);
    check("s1_wdata",  64'(MemWData), 64'd7);
    check("s1_count",  64'(Count),    64'd1);
    check("s1_empty",  64'(Empty),    64'd0);
    MemAck = 1'b1;
    step();
    MemAck = 1'b0;
    check("s1_count_after_ack",  64'(Count),  64'd0);
    check("s1_memreq_after_ack", 64'(MemReq), 64'd0);
    check("s1_empty_after_ack",  64'(Empty),  64'd1);

    // Ack while idle is ignored
    MemAck = 1'b1;
    step();
    MemAck = 1'b0;
    check("idle_ack_count",  64'(Count),  64'd0);
    check("idle_ack_memreq", 64'(MemReq), 64'd0);

    // Fill to full with no ack
    for (int i = 0; i < 4; i++) begin
      MemWrite = 1'b1; DataAdr = AW'(4 * i); WriteData = DW'(4 * i + 1);
      step();
      check("fill_count", 64'(Count), 64'(i + 1));
    end
    check("full_stall",  64'(Stall),  64'd1);
    check("full_memadr", 64'(MemAdr), 64'd0);

    // Fifth store is held while full; request stays stable
    DataAdr = 16; WriteData = 17;
    step();
    check("held_count",  64'(Count),    64'd4);
    check("held_stall",  64'(Stall),    64'd1);
    check("held_memadr", 64'(MemAdr),   64'd0);
    check("held_wdata",  64'(MemWData), 64'd1);

    // Pop while full with store pending: pop only
    MemAck = 1'b1;
    step();
    MemAck = 1'b0;
    check("fullpop_count",  64'(Count),  64'd3);
    check("fullpop_stall",  64'(Stall),  64'd0);
    check("fullpop_memadr", 64'(MemAdr), 64'd4);
    // Held store now accepted
    step();
    MemWrite = 1'b0;
    check("late_push_count", 64'(Count), 64'd4);
    check("late_push_stall", 64'(Stall), 64'd1);

    // Drain: memory sees 4,8,12,16 (0 already popped above)
    exp_order[0] = 4; exp_order[1] = 8; exp_order[2] = 12; exp_order[3] = 16;
    MemAck = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_memadr", 64'(MemAdr),   64'(exp_order[i]));
      check("drain_wdata",  64'(MemWData), 64'(exp_order[i] + 1));
      step();
    end
    MemAck = 1'b0;
    check("drain_empty",  64'(Empty),  64'd1);
    check("drain_memreq", 64'(MemReq), 64'd0);

    // Simultaneous push and pop at Count=2
    MemWrite = 1'b1; DataAdr = 200; WriteData = 32'hA;
    step();
    DataAdr = 204; WriteData = 32'hB;
    step();
    check("pp_count_pre",  64'(Count),  64'd2);
    check("pp_memadr_pre", 64'(MemAdr), 64'd200);
    DataAdr = 208; WriteData = 32'hC; MemAck = 1'b1;
    step();
    MemWrite = 1'b0;
    check("pp_count",  64'(Count),  64'd2);
    check("pp_memadr", 64'(MemAdr), 64'd204);
    step();
    check("pp_memadr2", 64'(MemAdr),   64'd208);
    check("pp_wdata2",  64'(MemWData), 64'hC);
    check("pp_count2",  64'(Count),    64'd1);
    step();
    MemAck = 1'b0;
    check("pp_empty",  64'(Empty),  64'd1);
    check("pp_memreq", 64'(MemReq), 64'd0);

    // Forwarding: two stores to the same word, youngest wins
    MemWrite = 1'b1; DataAdr = 96; WriteData = 1;
    step();
    WriteData = 5;
    step();
    MemWrite = 1'b0;
    ReadAdr = 98;
    #1;
    check("fwd_hit_98",  64'(FwdHit),  fwd_on ? 64'd1 : 64'd0);
    check("fwd_data_98", 64'(FwdData), fwd_on ? 64'd5 : 64'd0);
    ReadAdr = 100;
    #1;
    check("fwd_hit_100",  64'(FwdHit),  64'd0);
    check("fwd_data_100", 64'(FwdData), 64'd0);
    // Store being pushed this cycle does not forward
    ReadAdr = 300; MemWrite = 1'b1; DataAdr = 300; WriteData = 9;
    #1;
    check("fwd_samecyc_hit", 64'(FwdHit), 64'd0);
    step();
    MemWrite = 1'b0;
    check("fwd_after_hit",  64'(FwdHit),  fwd_on ? 64'd1 : 64'd0);
    check("fwd_after_data", 64'(FwdData), fwd_on ? 64'd9 : 64'd0);
    check("three_count",  64'(Count),  64'd3);
    check("three_memreq", 64'(MemReq), 64'd1);

    // Asynchronous reset mid-drain discards pending entries
    MemAck = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    check("arst_memreq", 64'(MemReq), 64'd0);
    check("arst_count",  64'(Count),  64'd0);
    check("arst_empty",  64'(Empty),  64'd1);
    check("arst_memadr", 64'(MemAdr), 64'd0);
    check("arst_fwdhit", 64'(FwdHit), 64'd0);
    step();
    reset = 1'b0;
    step();
    step();
    check("post_rst_count",  64'(Count),  64'd0);
    check("post_rst_memreq", 64'(MemReq), 64'd0);
    check("post_rst_stall",  64'(Stall),  64'd0);
    MemAck = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 The block SHALL have one clock, clk, and an asynchronous active-high reset, reset; the same reset clears every register.
REQ-002 Parameter DEPTH, 4, number of buffered stores (power of two, 2..16).
REQ-003 Parameter AW, 32, address width.
REQ-004 Parameter DW, 32, data width.
REQ-005 Port clk  in  1  rising-edge clock.
REQ-006 Port reset  in  1  asynchronous active-high reset.
REQ-007 Port MemWrite  in  1  core store request.
REQ-008 Port DataAdr  in  AW  core store byte address.
REQ-009 Port WriteData  in  DW  core store data.
REQ-010 Port Stall  out  1  buffer full; the core holds its store.
REQ-011 Port ReadAdr  in  AW  core load address for the forwarding lookup.
REQ-012 Port FwdHit  out  1  a buffered store matches ReadAdr.
REQ-013 Port FwdData  out  DW  data of the youngest matching store.
REQ-014 Port MemReq  out  1  write request to data memory.
REQ-015 Port MemAdr  out  AW  head-entry address.
REQ-016 Port MemWData  out  DW  head-entry data.
REQ-017 Port MemAck  in  1  memory accepts the write this cycle.
REQ-018 Port Count  out  $clog2(DEPTH)+1  number of occupied entries.
REQ-019 Port Empty  out  1  Count==0.

Function
REQ-020 The buffer SHALL be an in-order circular FIFO of {addr,data} entries with head/tail pointers that wrap modulo DEPTH.
REQ-021 A push SHALL occur when MemWrite=1 and Stall=0, writing {DataAdr,WriteData} at the tail on the rising edge.
REQ-022 Stall SHALL be registered and equal 1 exactly when Count==DEPTH; a store with Stall=1 SHALL be ignored, so the core must hold it.
REQ-023 The drain FSM SHALL have two states: IDLE (Empty=1, MemReq=0) and DRAIN (MemReq=1; MemAdr/MemWData show the head entry).
REQ-024 In the cycle after a push into an empty buffer, the FSM SHALL enter DRAIN and assert MemReq, giving one cycle of push-to-request latency.
REQ-025 A pop SHALL occur when MemReq=1 and MemAck=1; the head advances on that edge.
REQ-026 MemReq, MemAdr and MemWData SHALL stay stable while MemAck=0.
REQ-027 After the last entry pops, the FSM SHALL return to IDLE in the same edge and drive MemReq=0 in the next cycle.
REQ-028 On a push and pop in the same cycle (not full), Count SHALL stay unchanged and both pointers SHALL advance.
REQ-029 When full, a pop with MemWrite=1 SHALL pop only; Stall drops on the next cycle and the store is accepted then.
REQ-030 MemAck while MemReq=0 SHALL be ignored.
REQ-031 Forwarding (when enabled) SHALL be combinational and match on word address (addr[AW-1:2]) against valid entries only.
REQ-032 When several entries match, forwarding SHALL return the youngest.
REQ-033 A store being pushed in the same cycle SHALL NOT forward.
REQ-034 FwdData SHALL be 0 when FwdHit=0.

Reset
REQ-035 Asserting reset SHALL immediately drive Count=0, Empty=1, Stall=0, MemReq=0, MemAdr=0, MemWData=0, FwdHit=0, FwdData=0, both pointers to 0 and the FSM to IDLE.
REQ-036 Asserting reset mid-drain SHALL discard all pending entries; they SHALL NOT reach memory.
REQ-037 The first push SHALL be accepted on the first rising edge after reset deasserts.

Configuration
REQ-038 With macro STORE_BUFFER_FWD_EN defined, the block SHALL implement forwarding per REQ-031 to REQ-034.
REQ-039 With STORE_BUFFER_FWD_EN undefined, the block SHALL tie FwdHit=0 and FwdData=0, ignore ReadAdr, and build no compare logic; all other behaviour SHALL be identical.

Verification
REQ-040 Reset, then MemWrite with DataAdr=100 and WriteData=7 for one cycle, MemAck=0 -> the next cycle shows MemReq=1, MemAdr=100, MemWData=7, Count=1; MemAck=1 for one cycle -> Count=0 and MemReq=0 the following cycle.
REQ-041 MemAck=0 with 5 consecutive stores to 0,4,8,12,16 -> Stall=1 and Count=4 after the 4th; the 5th is held; one MemAck -> store 16 is accepted and memory sees the order 0,4,8,12,16.
REQ-042 Count=2, then a push and MemAck in the same cycle -> Count stays 2 and MemAdr advances to the second entry.
REQ-043 STORE_BUFFER_FWD_EN defined, stores (96,1) then (96,5), MemAck=0, ReadAdr=98 -> FwdHit=1, FwdData=5; ReadAdr=100 -> FwdHit=0, FwdData=0; with the macro undefined -> FwdHit=0 always.
REQ-044 Three entries buffered, MemReq=1, then reset asserted asynchronously between edges -> MemReq=0, Count=0 and Empty=1 immediately, and no MemAck-driven pop after reset releases.
